// File: rtl/br_pkg.sv
// Shared definitions for the ID-stage branch resolution controller:
// op codes, FSM state encodings, counter indices and small decode helpers.
package br_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_GE   = 3'b011;
    localparam logic [2:0] BR_GTZ  = 3'b100;
    localparam logic [2:0] BR_LEZ  = 3'b101;
    localparam logic [2:0] BR_LTZ  = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    localparam int NUM_CNT    = 3;
    localparam int CNT_BRANCH = 0;
    localparam int CNT_TAKEN  = 1;
    localparam int CNT_STALL  = 2;

    typedef struct packed {
        logic stall;
        logic taken;
        logic branch;
    } cnt_inc_t;

    function automatic logic is_branch_op(input logic [2:0] op);
        return (op != BR_NONE) && (op != BR_RSVD);
    endfunction

    function automatic logic needs_rt(input logic [2:0] op);
        return (op == BR_EQ) || (op == BR_NE) || (op == BR_GE);
    endfunction

    // Offset is in words; wrap-around past 2^32 is intentionally silent.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Signed branch condition evaluator; purely combinational so it can be
// exercised on its own.
module branch_cmp
    import br_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic        taken
);

    logic signed [31:0] sa;
    logic signed [31:0] sb;

    assign sa = a;
    assign sb = b;

    always_comb begin
        taken = 1'b0;
        case (op)
            BR_EQ:   taken = (sa == sb);
            BR_NE:   taken = (sa != sb);
            BR_GE:   taken = (sa >= sb);
            BR_GTZ:  taken = (sa >  32'sd0);
            BR_LEZ:  taken = (sa <= 32'sd0);
            BR_LTZ:  taken = (sa <  32'sd0);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: waits for operands, resolves the condition,
// hands taken-branch redirects to fetch and keeps saturating perf counters.
module branch_ctrl
    import br_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_br_op,
    input  logic [31:0]      id_pc,
    input  logic [15:0]      id_imm16,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             flush,
    input  logic             if_ready,
    input  logic             cnt_clr,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             wait_err,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_stall
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [1:0]         state_reg, state_next;
    logic [7:0]         wait_cnt_reg, wait_cnt_next;
    logic               wait_err_reg, wait_err_next;
    logic               redirect_valid_reg, redirect_valid_next;
    logic [31:0]        redirect_pc_reg, redirect_pc_next;

    logic               br_present;
    logic               opnd_ready;
    logic               cond_taken;
    logic               stall;
    logic [31:0]        target;
    cnt_inc_t           inc;
    logic [NUM_CNT-1:0] inc_vec;

    branch_cmp u_cmp (
        .a     (rs_val),
        .b     (rt_val),
        .op    (id_br_op),
        .taken (cond_taken)
    );

    assign br_present = id_valid && is_branch_op(id_br_op);
    assign opnd_ready = rs_ready && (!needs_rt(id_br_op) || rt_ready);
    assign target     = branch_target(id_pc, id_imm16);

    // A branch behind an unaccepted redirect must wait for IDLE even if its
    // operands are ready; flush always releases the stall.
    always_comb begin
        stall = 1'b0;
        if (!flush && br_present) begin
            if (state_reg == ST_REDIR) begin
                stall = 1'b1;
            end else begin
                stall = !opnd_ready;
            end
        end
    end

    always_comb begin
        state_next          = state_reg;
        wait_cnt_next       = wait_cnt_reg;
        wait_err_next       = 1'b0;
        redirect_valid_next = redirect_valid_reg;
        redirect_pc_next    = redirect_pc_reg;
        inc                 = '0;

        if (flush) begin
            state_next          = ST_IDLE;
            wait_cnt_next       = 8'd0;
            redirect_valid_next = 1'b0;
        end else begin
            inc.stall = stall;
            case (state_reg)
                ST_IDLE, ST_WAIT: begin
                    if (!br_present) begin
                        state_next    = ST_IDLE;
                        wait_cnt_next = 8'd0;
                    end else if (opnd_ready) begin
                        inc.branch    = 1'b1;
                        wait_cnt_next = 8'd0;
                        if (cond_taken) begin
                            inc.taken           = 1'b1;
                            redirect_valid_next = 1'b1;
                            redirect_pc_next    = target;
                            state_next          = ST_REDIR;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        state_next = ST_WAIT;
                        if (state_reg == ST_IDLE) begin
                            wait_cnt_next = 8'd1;
                        end else if (wait_cnt_reg < MAX_WAIT_C) begin
                            wait_cnt_next = wait_cnt_reg + 8'd1;
                        end
                        // Pulse only on the step onto MAX_WAIT; the count then holds.
                        wait_err_next = (wait_cnt_next == MAX_WAIT_C) &&
                                        (wait_cnt_next != wait_cnt_reg);
                    end
                end
                ST_REDIR: begin
                    if (if_ready) begin
                        redirect_valid_next = 1'b0;
                        state_next          = ST_IDLE;
                    end
                end
                default: begin
                    state_next          = ST_IDLE;
                    wait_cnt_next       = 8'd0;
                    redirect_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            wait_cnt_reg       <= 8'd0;
            wait_err_reg       <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= 32'd0;
        end else begin
            state_reg          <= state_next;
            wait_cnt_reg       <= wait_cnt_next;
            wait_err_reg       <= wait_err_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
        end
    end

    assign inc_vec = {inc.stall, inc.taken, inc.branch};

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= '0;
                end else if (inc_vec[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_id       = stall;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;
    assign wait_err       = wait_err_reg;
    assign cnt_branch     = gen_cnt[CNT_BRANCH].cnt_reg;
    assign cnt_taken      = gen_cnt[CNT_TAKEN].cnt_reg;
    assign cnt_stall      = gen_cnt[CNT_STALL].cnt_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the controller.
module tb_branch_ctrl;

    localparam int CNT_W    = 2;
    localparam int MAX_WAIT = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [2:0]       id_br_op;
    logic [31:0]      id_pc;
    logic [15:0]      id_imm16;
    logic [31:0]      rs_val, rt_val;
    logic             rs_ready, rt_ready;
    logic             flush, if_ready, cnt_clr;
    logic             stall_id, redirect_valid, wait_err;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] cnt_branch, cnt_taken, cnt_stall;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit          m_pend;
    logic [31:0] m_pc;
    int          m_wcnt;
    bit          m_err;
    int          m_cb, m_ct, m_cs;

    always #5 clk = ~clk;

    branch_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_br_op       (id_br_op),
        .id_pc          (id_pc),
        .id_imm16       (id_imm16),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .rs_ready       (rs_ready),
        .rt_ready       (rt_ready),
        .flush          (flush),
        .if_ready       (if_ready),
        .cnt_clr        (cnt_clr),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .wait_err       (wait_err),
        .cnt_branch     (cnt_branch),
        .cnt_taken      (cnt_taken),
        .cnt_stall      (cnt_stall)
    );

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic bit f_branch();
        return id_valid && (id_br_op >= 3'd1) && (id_br_op <= 3'd6);
    endfunction

    function automatic bit f_ready();
        return rs_ready && ((id_br_op >= 3'd4) || rt_ready);
    endfunction

    function automatic bit f_taken();
        int a;
        int b;
        a = rs_val;
        b = rt_val;
        case (id_br_op)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return a >= b;
            3'd4:    return a > 0;
            3'd5:    return a <= 0;
            3'd6:    return a < 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] f_target();
        shortint off16;
        int      off;
        off16 = id_imm16;
        off   = off16;
        return id_pc + 32'd4 + 32'(off * 4);
    endfunction

    function automatic bit exp_stall();
        if (flush || !f_branch()) return 1'b0;
        if (m_pend) return 1'b1;
        return !f_ready();
    endfunction

    task automatic model_reset();
        m_pend = 0; m_pc = 32'd0; m_wcnt = 0; m_err = 0;
        m_cb = 0; m_ct = 0; m_cs = 0;
    endtask

    // Advance one clock edge and update the model with the pre-edge inputs.
    task automatic step();
        bit st;
        st = exp_stall();
        @(posedge clk);
        m_err = 0;
        if (flush) begin
            m_pend = 0;
            m_wcnt = 0;
        end else if (m_pend) begin
            if (if_ready) m_pend = 0;
        end else if (f_branch()) begin
            if (f_ready()) begin
                m_cb   = sat(m_cb + 1);
                m_wcnt = 0;
                if (f_taken()) begin
                    m_pend = 1;
                    m_pc   = f_target();
                    m_ct   = sat(m_ct + 1);
                end
                $display("txn op=%0d pc=%08h rs=%08h rt=%08h taken=%0b target=%08h",
                         id_br_op, id_pc, rs_val, rt_val, f_taken(), f_target());
            end else if (m_wcnt < MAX_WAIT) begin
                m_wcnt = m_wcnt + 1;
                if (m_wcnt == MAX_WAIT) m_err = 1;
            end
        end else begin
            m_wcnt = 0;
        end
        if (st) m_cs = sat(m_cs + 1);
        if (cnt_clr) begin
            m_cb = 0; m_ct = 0; m_cs = 0;
        end
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_br_op = 3'd0; flush = 0; cnt_clr = 0; if_ready = 0;
        rs_ready = 1; rt_ready = 1;
    endtask

    task automatic clear_counters();
        set_idle();
        cnt_clr = 1;
        step();
        cnt_clr = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        set_idle();
        rs_val = 0; rt_val = 0; id_pc = 0; id_imm16 = 0;
        #3;
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || wait_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs got valid=%0b pc=%08h err=%0b exp 0/00000000/0",
                     redirect_valid, redirect_pc, wait_err);
        end
        checks++;
        if (cnt_branch !== '0 || cnt_taken !== '0 || cnt_stall !== '0 || stall_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt got %0d/%0d/%0d stall=%0b exp 0/0/0 stall=0",
                     cnt_branch, cnt_taken, cnt_stall, stall_id);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_eq_taken();
        clear_counters();
        id_valid = 1; id_br_op = 3'b001; rs_val = 5; rt_val = 5;
        id_pc = 32'h0000_3000; id_imm16 = 16'h0004;
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++; $display("FAIL eq_stall got=%0b exp=0", stall_id);
        end
        step();
        id_valid = 0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_3014) begin
            failures++;
            $display("FAIL eq_redirect got valid=%0b pc=%08h exp 1/00003014", redirect_valid, redirect_pc);
        end
        checks++;
        if (cnt_branch !== 2'd1 || cnt_taken !== 2'd1) begin
            failures++;
            $display("FAIL eq_counters got br=%0d tk=%0d exp 1/1", cnt_branch, cnt_taken);
        end
        if_ready = 1;
        step();
        if_ready = 0;
        checks++;
        if (redirect_valid !== 1'b0) begin
            failures++; $display("FAIL eq_handshake got valid=%0b exp=0", redirect_valid);
        end
    endtask

    task automatic test_zero_cmp();
        clear_counters();
        id_valid = 1; id_br_op = 3'b111; rs_ready = 0; rt_ready = 0;
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++; $display("FAIL rsvd_stall got=%0b exp=0", stall_id);
        end
        step();
        id_br_op = 3'b000;
        step();
        checks++;
        if (cnt_branch !== 2'd0 || cnt_stall !== 2'd0 || redirect_valid !== 1'b0) begin
            failures++;
            $display("FAIL nonbranch_ignored got br=%0d st=%0d valid=%0b exp 0/0/0",
                     cnt_branch, cnt_stall, redirect_valid);
        end
        rs_ready = 1; rt_ready = 1;
        id_br_op = 3'b110; rs_val = 32'h0; id_pc = 32'h100; id_imm16 = 16'h0010;
        step();
        checks++;
        if (redirect_valid !== 1'b0) begin
            failures++; $display("FAIL ltz_zero got valid=%0b exp=0", redirect_valid);
        end
        id_br_op = 3'b100; rs_val = 32'h8000_0000;
        step();
        checks++;
        if (redirect_valid !== 1'b0) begin
            failures++; $display("FAIL gtz_neg got valid=%0b exp=0", redirect_valid);
        end
        id_br_op = 3'b101; rs_val = 32'hFFFF_FFFF; id_pc = 32'h0000_4000; id_imm16 = 16'hFFFF;
        step();
        id_valid = 0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_4000) begin
            failures++;
            $display("FAIL lez_back got valid=%0b pc=%08h exp 1/00004000", redirect_valid, redirect_pc);
        end
        checks++;
        if (cnt_branch !== 2'd3 || cnt_taken !== 2'd1) begin
            failures++;
            $display("FAIL zero_counters got br=%0d tk=%0d exp 3/1", cnt_branch, cnt_taken);
        end
        if_ready = 1;
        step();
        if_ready = 0;
    endtask

    task automatic test_wait();
        int pulses;
        clear_counters();
        id_valid = 1; id_br_op = 3'b010; rs_val = 1; rt_val = 2; rt_ready = 0;
        id_pc = 32'h200; id_imm16 = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_id !== 1'b1) begin
                failures++; $display("FAIL wait_stall cyc=%0d got=%0b exp=1", i, stall_id);
            end
            step();
            checks++;
            if (wait_err !== (i == 1) || redirect_valid !== 1'b0) begin
                failures++;
                $display("FAIL wait_err cyc=%0d got err=%0b valid=%0b exp err=%0b valid=0",
                         i, wait_err, redirect_valid, (i == 1));
            end
        end
        rt_ready = 1;
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++; $display("FAIL wait_release got=%0b exp=0", stall_id);
        end
        step();
        id_valid = 0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_020C || cnt_stall !== 2'd3 ||
            cnt_branch !== 2'd1 || wait_err !== 1'b0) begin
            failures++;
            $display("FAIL wait_resolve got valid=%0b pc=%08h st=%0d br=%0d err=%0b exp 1/0000020c/3/1/0",
                     redirect_valid, redirect_pc, cnt_stall, cnt_branch, wait_err);
        end
        if_ready = 1;
        step();
        if_ready = 0;
        // Long wait: exactly one pulse no matter how long it lasts.
        pulses = 0;
        id_valid = 1; id_br_op = 3'b001; rs_ready = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (wait_err === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++; $display("FAIL wait_err_once got=%0d exp=1", pulses);
        end
        set_idle();
        step();
    endtask

    task automatic test_redirect_hold();
        clear_counters();
        id_valid = 1; id_br_op = 3'b011; rs_val = 7; rt_val = 32'hFFFF_FFFD;
        id_pc = 32'h1000; id_imm16 = 16'h0100;
        step();
        id_br_op = 3'b001; rs_val = 1; rt_val = 1; id_pc = 32'h1008; id_imm16 = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (stall_id !== 1'b1) begin
                failures++; $display("FAIL hold_stall cyc=%0d got=%0b exp=1", i, stall_id);
            end
            step();
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1404) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got valid=%0b pc=%08h exp 1/00001404",
                         i, redirect_valid, redirect_pc);
            end
        end
        if_ready = 1;
        #1;
        checks++;
        if (stall_id !== 1'b1) begin
            failures++; $display("FAIL hold_accept_stall got=%0b exp=1", stall_id);
        end
        step();
        if_ready = 0;
        checks++;
        if (redirect_valid !== 1'b0 || cnt_branch !== 2'd1) begin
            failures++;
            $display("FAIL hold_accept got valid=%0b br=%0d exp 0/1", redirect_valid, cnt_branch);
        end
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++; $display("FAIL second_resolve_stall got=%0b exp=0", stall_id);
        end
        step();
        id_valid = 0;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1010 || cnt_branch !== 2'd2) begin
            failures++;
            $display("FAIL second_redirect got valid=%0b pc=%08h br=%0d exp 1/00001010/2",
                     redirect_valid, redirect_pc, cnt_branch);
        end
        if_ready = 1;
        step();
        if_ready = 0;
    endtask

    task automatic test_flush();
        clear_counters();
        id_valid = 1; id_br_op = 3'b010; rs_val = 3; rt_val = 4; rt_ready = 0;
        id_pc = 32'h500; id_imm16 = 16'h0008;
        step();
        flush = 1;
        #1;
        checks++;
        if (stall_id !== 1'b0) begin
            failures++; $display("FAIL flush_stall got=%0b exp=0", stall_id);
        end
        step();
        flush = 0; id_valid = 0;
        checks++;
        if (redirect_valid !== 1'b0 || cnt_branch !== 2'd0 || cnt_stall !== 2'd1) begin
            failures++;
            $display("FAIL flush_wait got valid=%0b br=%0d st=%0d exp 0/0/1",
                     redirect_valid, cnt_branch, cnt_stall);
        end
        step();
        id_valid = 1; id_br_op = 3'b001; rs_val = 9; rt_val = 9; rt_ready = 1;
        step();
        checks++;
        if (redirect_valid !== 1'b1) begin
            failures++; $display("FAIL flush_setup got valid=%0b exp=1", redirect_valid);
        end
        flush = 1; if_ready = 1;
        step();
        flush = 0; if_ready = 0; id_valid = 0;
        checks++;
        if (redirect_valid !== 1'b0 || cnt_branch !== 2'd1 || cnt_taken !== 2'd1) begin
            failures++;
            $display("FAIL flush_redirect got valid=%0b br=%0d tk=%0d exp 0/1/1",
                     redirect_valid, cnt_branch, cnt_taken);
        end
        step();
    endtask

    task automatic test_saturate();
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            id_valid = 1; id_br_op = 3'b001; rs_val = i; rt_val = i;
            id_pc = 32'h2000 + 32'(i * 16); id_imm16 = 16'h0003;
            step();
            id_valid = 0; if_ready = 1;
            step();
            if_ready = 0;
        end
        checks++;
        if (cnt_taken !== 2'd3 || cnt_branch !== 2'd3 || cnt_stall !== 2'd0) begin
            failures++;
            $display("FAIL saturate got br=%0d tk=%0d st=%0d exp 3/3/0", cnt_branch, cnt_taken, cnt_stall);
        end
        id_valid = 1; cnt_clr = 1;
        step();
        cnt_clr = 0; id_valid = 0;
        checks++;
        if (cnt_branch !== 2'd0 || cnt_taken !== 2'd0 || cnt_stall !== 2'd0 || redirect_valid !== 1'b1) begin
            failures++;
            $display("FAIL clr_priority got br=%0d tk=%0d st=%0d valid=%0b exp 0/0/0/1",
                     cnt_branch, cnt_taken, cnt_stall, redirect_valid);
        end
        if_ready = 1;
        step();
        if_ready = 0;
    endtask

    task automatic test_async_reset();
        set_idle();
        id_valid = 1; id_br_op = 3'b001; rs_val = 4; rt_val = 4; id_pc = 32'h600; id_imm16 = 16'h0001;
        step();
        id_valid = 0;
        #2;
        reset = 1;
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || cnt_branch !== '0 || cnt_taken !== '0) begin
            failures++;
            $display("FAIL async_reset got valid=%0b pc=%08h br=%0d tk=%0d exp 0/00000000/0/0",
                     redirect_valid, redirect_pc, cnt_branch, cnt_taken);
        end
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        step();
        checks++;
        if (redirect_valid !== 1'b0) begin
            failures++; $display("FAIL reset_no_redirect got valid=%0b exp=0", redirect_valid);
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        set_idle();
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(0, 9) < 8);
            id_br_op = 3'($urandom_range(0, 7));
            id_pc    = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            id_imm16 = 16'($urandom);
            rs_val   = pick_val();
            rt_val   = ($urandom_range(0, 2) == 0) ? rs_val : pick_val();
            rs_ready = ($urandom_range(0, 9) < 8);
            rt_ready = ($urandom_range(0, 3) < 3);
            if_ready = ($urandom_range(0, 9) < 4);
            flush    = ($urandom_range(0, 24) == 0);
            cnt_clr  = ($urandom_range(0, 29) == 0);
            #1;
            checks++;
            if (stall_id !== exp_stall()) begin
                failures++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", i, stall_id, exp_stall());
            end
            step();
            checks++;
            if (redirect_valid !== m_pend || (m_pend && redirect_pc !== m_pc) || wait_err !== m_err) begin
                failures++;
                $display("FAIL rnd_regs cyc=%0d got valid=%0b pc=%08h err=%0b exp valid=%0b pc=%08h err=%0b",
                         i, redirect_valid, redirect_pc, wait_err, m_pend, m_pc, m_err);
            end
            checks++;
            if (cnt_branch !== CNT_W'(m_cb) || cnt_taken !== CNT_W'(m_ct) || cnt_stall !== CNT_W'(m_cs)) begin
                failures++;
                $display("FAIL rnd_cnt cyc=%0d got %0d/%0d/%0d exp %0d/%0d/%0d",
                         i, cnt_branch, cnt_taken, cnt_stall, m_cb, m_ct, m_cs);
            end
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_eq_taken();
        test_zero_cmp();
        test_wait();
        test_redirect_hold();
        test_flush();
        test_saturate();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
